// File: rtl/ping_pong_pkg.sv
// Shared types for the ping-pong buffer: per-bank lifecycle state and
// small predicates on it.
package ping_pong_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    function automatic logic is_writable(input bank_state_t s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

    function automatic logic is_readable(input bank_state_t s);
        return (s == FULL) || (s == DRAINING);
    endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// Simple dual-port RAM with a read-enabled output register; both banks share
// one array and are selected by the address MSB.
module pp_bank_ram #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 11
) (
    input  logic              clk_100,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: no reset on the array or its read register, so the tools can map
    // both onto block RAM; validity is tracked by the control logic instead.
    always_ff @(posedge clk_100) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register holds its value when rd_en is low (backpressure).
    always_ff @(posedge clk_100) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ping_pong_buf.sv
// Double-bank ping-pong buffer: the write stream fills one bank while the read
// stream drains the other, with partial-bank close, backpressure and flush.
module ping_pong_buf
    import ping_pong_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 1024
) (
    input  logic              clk_100,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic [1:0]        bank_full,
    output logic              wr_bank,
    output logic              rd_bank
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bank_state_t       state     [2];
    bank_state_t       state_nxt [2];
    logic [LEN_W-1:0]  len       [2];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              out_bank;

    logic wr_fire, wr_close;
    logic rd_issue, rd_issue_last, rd_hs, rd_done;
    logic [LEN_W-1:0] rd_addr_ext;

    assign wr_ready = en && is_writable(state[wr_bank]);
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_close = wr_fire && (wr_last || (wr_addr == LAST_ADDR));

    // The issue pointer moves to the other bank as soon as the last word of
    // a bank is issued, so reads continue back-to-back across banks.
    assign rd_addr_ext   = LEN_W'(rd_addr);
    assign rd_issue      = is_readable(state[rd_bank]) && (rd_addr_ext < len[rd_bank])
                           && (!rd_valid || rd_ready);
    assign rd_issue_last = rd_issue && (rd_addr_ext == len[rd_bank] - LEN_W'(1));
    assign rd_hs         = rd_valid && rd_ready;
    assign rd_done       = rd_hs && rd_last;

    assign bank_full = {is_readable(state[1]), is_readable(state[0])};

    // NOTE: every output of this always_comb is defaulted first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            case (state[i])
                EMPTY, FILLING: if (wr_fire && wr_bank == 1'(i))
                                    state_nxt[i] = wr_close ? FULL : FILLING;
                FULL:           if (rd_issue && rd_bank == 1'(i))
                                    state_nxt[i] = DRAINING;
                DRAINING:       if (rd_done && out_bank == 1'(i))
                                    state_nxt[i] = EMPTY;
                default:        state_nxt[i] = state[i];
            endcase
        end
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
        end else if (flush) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
        end else begin
            state[0] <= state_nxt[0];
            state[1] <= state_nxt[1];
        end
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            len[0]  <= '0;
            len[1]  <= '0;
            wr_addr <= '0;
            wr_bank <= 1'b0;
        end else if (flush) begin
            len[0]  <= '0;
            len[1]  <= '0;
            wr_addr <= '0;
            wr_bank <= 1'b0;
        end else if (wr_fire) begin
            if (wr_close) begin
                len[wr_bank] <= LEN_W'(wr_addr) + LEN_W'(1);
                wr_addr      <= '0;
                wr_bank      <= ~wr_bank;
            end else begin
                wr_addr <= wr_addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr  <= '0;
            rd_bank  <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            out_bank <= 1'b0;
        end else if (flush) begin
            rd_addr  <= '0;
            rd_bank  <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            out_bank <= 1'b0;
        end else if (rd_issue) begin
            rd_valid <= 1'b1;
            rd_last  <= rd_issue_last;
            out_bank <= rd_bank;
            if (rd_issue_last) begin
                rd_addr <= '0;
                rd_bank <= ~rd_bank;
            end else begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end
        end else if (rd_hs) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end
    end

    pp_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W + 1)
    ) u_ram (
        .clk_100 (clk_100),
        .wr_en   (wr_fire && !flush),
        .wr_addr ({wr_bank, wr_addr}),
        .wr_data (wr_data),
        .rd_en   (rd_issue && !flush),
        .rd_addr ({rd_bank, rd_addr}),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ping_pong_buf.sv
// Directed bench for ping_pong_buf (DEPTH=8, DATA_W=4): fill/drain, streaming,
// partial banks, backpressure, flush, async reset and write enable.
module tb_ping_pong_buf;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;

    logic              clk_100;
    logic              rst_n;
    logic              en;
    logic              flush;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_ready;
    logic [1:0]        bank_full;
    logic              wr_bank;
    logic              rd_bank;

    ping_pong_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_100   (clk_100),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .rd_ready  (rd_ready),
        .bank_full (bank_full),
        .wr_bank   (wr_bank),
        .rd_bank   (rd_bank)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected read stream: {last, data} per accepted write.
    logic [DATA_W:0] sb [$];
    int   mcnt;
    logic mbank;
    logic prev_rb;
    int   rb_toggles;
    int   gap_cnt;
    logic last_wfire;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        mcnt       = 0;
        mbank      = 1'b0;
        prev_rb    = 1'b0;
        rb_toggles = 0;
    endtask

    // One clock: capture handshakes before the edge, score them after it.
    task automatic tick();
        logic wf, rf, rl, wb, wl, exp_last;
        logic [DATA_W-1:0] rdat, wdat;
        logic [DATA_W:0]   e;
        wf   = wr_valid && wr_ready;
        rf   = rd_valid && rd_ready;
        rdat = rd_data;
        rl   = rd_last;
        wb   = wr_bank;
        wdat = wr_data;
        wl   = wr_last;
        @(posedge clk_100);
        #1;
        last_wfire = wf;
        if (wf) begin
            check("wr_bank", 32'(wb), 32'(mbank));
            exp_last = wl || (mcnt == DEPTH - 1);
            sb.push_back({exp_last, wdat});
            if (exp_last) begin
                mcnt  = 0;
                mbank = ~mbank;
            end else begin
                mcnt++;
            end
        end
        if (rf) begin
            if (sb.size() == 0) begin
                check("rd_extra", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("rd_data", 32'(rdat), 32'(e[DATA_W-1:0]));
                check("rd_last", 32'(rl), 32'(e[DATA_W]));
            end
        end
        if (rd_bank !== prev_rb) rb_toggles++;
        prev_rb = rd_bank;
    endtask

    task automatic wr_word(input logic [DATA_W-1:0] d, input logic l);
        int budget;
        wr_valid   = 1'b1;
        wr_data    = d;
        wr_last    = l;
        budget     = 0;
        last_wfire = 1'b0;
        while (!last_wfire && budget < 50) begin
            tick();
            if (!last_wfire) gap_cnt++;
            budget++;
        end
        if (!last_wfire) check("wr_timeout", 32'(last_wfire), 32'd1);
    endtask

    task automatic drain(input int budget);
        int n;
        n        = 0;
        rd_ready = 1'b1;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b1;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        rd_ready = 1'b0;
        repeat (2) @(posedge clk_100);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
        check({tag, "_rd_last"},   32'(rd_last),   32'd0);
        check({tag, "_bank_full"}, 32'(bank_full), 32'd0);
        check({tag, "_wr_bank"},   32'(wr_bank),   32'd0);
        check({tag, "_rd_bank"},   32'(rd_bank),   32'd0);
        check({tag, "_wr_ready"},  32'(wr_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int budget;

        // Reset state
        do_reset();
        check_idle("reset");

        // 1: single fill, latency of 2 cycles after the closing write
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) wr_word(DATA_W'(i), 1'b0);
        wr_valid = 1'b0;
        check("t1_valid_cycle1", 32'(rd_valid), 32'd0);
        tick();
        check("t1_valid_cycle2", 32'(rd_valid), 32'd1);
        drain(40);

        // 2: continuous streaming of 48 words
        do_reset();
        rd_ready = 1'b1;
        gap_cnt  = 0;
        for (int i = 0; i < 48; i++) wr_word(DATA_W'(i % 16), 1'b0);
        wr_valid = 1'b0;
        drain(60);
        check("t2_wr_gaps", 32'(gap_cnt), 32'd2);
        check("t2_rd_bank_toggles", 32'(rb_toggles), 32'd6);

        // 3: partial bank closed by wr_last on the third word
        do_reset();
        wr_word(4'hA, 1'b0);
        wr_word(4'hB, 1'b0);
        wr_word(4'hC, 1'b1);
        wr_valid = 1'b0;
        check("t3_bank_full", 32'(bank_full), 32'b01);
        check("t3_wr_bank", 32'(wr_bank), 32'd1);
        wr_word(4'hD, 1'b1);
        wr_valid = 1'b0;
        check("t3_bank_full_both", 32'(bank_full), 32'b11);
        drain(30);

        // 4: backpressure with both banks full
        do_reset();
        for (int i = 0; i < 2 * DEPTH; i++) wr_word(DATA_W'(15 - i), 1'b0);
        wr_valid = 1'b0;
        check("t4_bank_full", 32'(bank_full), 32'b11);
        check("t4_wr_ready", 32'(wr_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_hold_valid", 32'(rd_valid), 32'd1);
            check("t4_hold_data", 32'(rd_data), 32'hF);
        end
        drain(60);
        check("t4_bank_full_after", 32'(bank_full), 32'b00);

        // 5: flush with bank 0 filling and bank 1 draining
        do_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) wr_word(DATA_W'(i + 1), 1'b0);
        wr_valid = 1'b0;
        drain(40);
        rd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) wr_word(DATA_W'(9), 1'b0);
        for (int i = 0; i < 4; i++) wr_word(DATA_W'(7), 1'b0);
        wr_valid = 1'b0;
        check("t5_pre_flush_full", 32'(bank_full), 32'b10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
        check_idle("t5_flush");
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) wr_word(DATA_W'(DEPTH - 1 - i), 1'b0);
        wr_valid = 1'b0;
        drain(40);

        // 6a: asynchronous reset in the middle of a drain
        do_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) wr_word(DATA_W'(i + 4), 1'b0);
        wr_valid = 1'b0;
        tick();
        tick();
        check("t6_mid_drain_valid", 32'(rd_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_rd_valid", 32'(rd_valid), 32'd0);
        check("t6_async_bank_full", 32'(bank_full), 32'b00);
        model_clear();
        #2 rst_n = 1'b1;

        // 6b: en low blocks writes while both banks still drain
        rd_ready = 1'b0;
        for (int i = 0; i < 2 * DEPTH; i++) wr_word(DATA_W'(i + 2), 1'b0);
        wr_valid = 1'b0;
        en = 1'b0;
        #1;
        check("t6_en0_wr_ready", 32'(wr_ready), 32'd0);
        rd_ready = 1'b1;
        hi       = 0;
        budget   = 0;
        while (sb.size() > 0 && budget < 60) begin
            tick();
            if (wr_ready) hi++;
            budget++;
        end
        check("t6_en0_ready_seen", 32'(hi), 32'd0);
        check("t6_en0_drained", 32'(sb.size()), 32'd0);
        check("t6_en0_bank_full", 32'(bank_full), 32'b00);
        en = 1'b1;
        #1;
        check("t6_en1_wr_ready", 32'(wr_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ping_pong_buf.md
Name: ping_pong_buf

Overview:
Parametrised double-bank (ping-pong) buffer with independent valid/ready write and read streams.
- Write side fills one bank while the read side drains the other; banks swap automatically.
- Supports early bank close (wr_last) for partial frames, read backpressure, and synchronous flush.
- Storage is inferred dual-port RAM, with no vendor memory IP. It sits between a sample producer and a downstream consumer in the Nexys4 datapath.

Parameters:
- DATA_W, 4, word width in bits.
- DEPTH, 1024, words per bank; must be ≥2.
- ADDR_W, $clog2(DEPTH), localparam; bank address width.

Ports:
- clk_100  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  write enable; when low, wr_ready=0 and reads still drain.
- flush  in  1  synchronous clear of both banks, all pointers and the read output.
- wr_valid  in  1  write word present.
- wr_data  in  DATA_W  write word.
- wr_last  in  1  closes the current bank after this word (partial fill).
- wr_ready  out  1  write bank can accept a word.
- rd_valid  out  1  rd_data holds a valid word.
- rd_data  out  DATA_W  read word.
- rd_last  out  1  rd_data is the final word of its bank.
- rd_ready  in  1  consumer accepts the word.
- bank_full  out  2  bit i set when bank i is FULL or DRAINING.
- wr_bank  out  1  bank currently being written.
- rd_bank  out  1  bank currently being read.

Behaviour:
- Reset and flush state: both banks EMPTY; wr_bank=rd_bank=0; wr_addr=rd_addr=0; rd_valid=0; rd_last=0; bank_full=2'b00. rd_data is unspecified until the first rd_valid.
- Flush has priority over all other activity in its cycle. An async reset mid-operation discards all contents.
- Per-bank state, a 2-bit enum:
  - EMPTY -> FILLING on the first accepted write.
  - FILLING -> FULL on an accepted write with wr_addr==DEPTH-1 or wr_last=1.
  - FULL -> DRAINING on the first read issue.
  - DRAINING -> EMPTY on the handshake of the rd_last word.
- Write acceptance: wr_ready = en && state[wr_bank] ∈ {EMPTY, FILLING}, computed from registered state only. A write is accepted when wr_valid && wr_ready.
- On an accepted write:
  - RAM[wr_bank][wr_addr] <= wr_data.
  - If the bank closes: store len[wr_bank] = wr_addr+1 (ADDR_W+1 bits), clear wr_addr, toggle wr_bank.
  - Otherwise: wr_addr+1.
- Read issue condition: state[rd_bank] ∈ {FULL, DRAINING} && rd_addr < len[rd_bank] && (!rd_valid || rd_ready).
- Read pipeline:
  - The RAM output register loads only on issue and holds otherwise, so rd_data stays stable under backpressure.
  - rd_valid is set the cycle after an issue.
  - rd_valid is cleared after a handshake when no new issue occurred.
  - rd_last is registered with the data: set when the issued address equals len-1.
- Read completion: on handshake of the rd_last word, the bank goes to EMPTY, rd_addr clears and rd_bank toggles.
- Latency: if the closing write is accepted in cycle 0, rd_valid=1 in cycle 2. Sustained throughput is 1 word/cycle per side.
- Streaming gap: with continuous wr_valid and rd_ready, wr_ready is low for exactly 1 cycle per 2*DEPTH words, while the bank being re-entered finishes its last read.
- Simultaneous events:
  - A write into bank X and a drain of bank Y are independent.
  - A bank freed by the last read becomes writable the next cycle, never the same cycle.
  - wr_last on the word at address DEPTH-1 is equivalent to a natural close.
- Both banks FULL: wr_ready=0 and bank_full=2'b11 until one bank drains.

Decomposition:
- Package ping_pong_pkg holds the bank_state_t enum (EMPTY, FILLING, FULL, DRAINING).
- One sub-module, pp_bank_ram: simple dual-port RAM of DEPTH x DATA_W with a registered read-enable output. It is instantiated twice, or once with 2*DEPTH depth using {bank, addr} addressing.

Test Plan:
(DEPTH=8, DATA_W=4)
1. Single fill: write 0..7 with rd_ready=1 -> rd_data 0..7 in order, rd_last only on 7, rd_valid first high 2 cycles after the write of 7.
2. Streaming: 48 words with wr_valid=rd_ready=1 continuously -> output equals input; wr_ready low exactly 1 cycle per 16 words; wr_bank and rd_bank alternate.
3. Partial bank: wr_last on the 3rd word (values A,B,C) -> read A,B,C with rd_last on C; the next write goes to bank 1 at address 0.
4. Backpressure: fill both banks with rd_ready=0 -> bank_full=2'b11, wr_ready=0, rd_data constant. Then release rd_ready -> 16 words in order and bank_full returns to 2'b00.
5. Flush mid-fill (4 words in bank 0, bank 1 draining) -> next cycle all state is reset-equivalent. Refill works and no stale words appear.
6. Controls: rst_n low mid-drain -> rd_valid=0 immediately (async). en=0 with bank 1 FULL -> wr_ready=0 while bank 1 still drains fully.
